// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arbiter: round-robin arbitration of byte requesters onto one UART tx.
// Optional parity bit: define UART_TX_ARBITER_PARITY_EN.      Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned BitCntW = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq*8-1:0]       req_data_i,
  output logic [NumReq-1:0]         req_ready_o,
  input  logic                      tx_enable_i,
  input  logic [BitCntW-1:0]        bit_cycles_i,
  input  logic                      parity_odd_i,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] grant_idx_o
);

  localparam int unsigned     IdxW      = $clog2(NumReq);
  localparam logic [IdxW:0]   NumReqExt = (IdxW+1)'(NumReq);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumReq - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_ARBITER_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]         state_q,   state_d;
  logic [BitCntW-1:0] cnt_q,     cnt_d;
  logic [BitCntW-1:0] period_q,  period_d;
  logic [7:0]         data_q,    data_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic               tx_q,      tx_d;
  logic [IdxW-1:0]    ptr_q,     ptr_d;
  logic [IdxW-1:0]    grant_q,   grant_d;

  logic               sel_found;
  logic [IdxW-1:0]    sel_idx;
  logic [IdxW:0]      cand;
  logic               grant_en;
  logic               bit_done;

`ifndef UART_TX_ARBITER_PARITY_EN
  logic unused_parity;
  assign unused_parity = parity_odd_i;
`endif

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (cand >= NumReqExt) cand = cand - NumReqExt;
      if (!sel_found && req_valid_i[cand[IdxW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Reset is folded in so ready reads zero while rst_ni is held low.
  assign grant_en = rst_ni && (state_q == IDLE) && tx_enable_i && sel_found;

  always_comb begin
    req_ready_o = '0;
    if (grant_en) req_ready_o[sel_idx] = 1'b1;
  end

  assign bit_done = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;

    if (state_q != IDLE) begin
      cnt_d = bit_done ? (period_q - BitCntW'(1)) : (cnt_q - BitCntW'(1));
    end

    case (state_q)
      IDLE: begin
        if (grant_en) begin
          period_d = (bit_cycles_i == '0) ? BitCntW'(1) : bit_cycles_i;
          cnt_d    = period_d - BitCntW'(1);
          data_d   = req_data_i[8*sel_idx +: 8];
          grant_d  = sel_idx;
          ptr_d    = (sel_idx == LastIdx) ? '0 : sel_idx + 1'b1;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = data_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_ARBITER_PARITY_EN
            state_d = PARITY;
            tx_d    = (^data_q) ^ parity_odd_i;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_ARBITER_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= BitCntW'(1);
      data_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ptr_q     <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_idx_o = grant_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one serial UART transmit line among NumReq byte requesters.
- Round-robin arbitration over valid/ready byte requests.
- Runtime-configured bit period; sequences start, data, optional parity and stop bits onto tx_o.
- Sits between on-chip producers (debug console, log unit, test mailbox) and the chip-level uart_tx pad.

Parameters:
- NumReq, 4, number of requesters (2..8).
- BitCntW, 16, width of the bit-period configuration and the internal bit-cycle counter.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_valid_i  input  NumReq  per-requester byte valid.
- req_data_i  input  NumReq*8  per-requester byte; requester k uses bits [8k+7:8k].
- req_ready_o  output  NumReq  per-requester accept; at most one bit high.
- tx_enable_i  input  1  permits new grants.
- bit_cycles_i  input  BitCntW  clk cycles per UART bit; 0 treated as 1.
- parity_odd_i  input  1  parity sense: 1 = odd, 0 = even. Ignored unless the optional feature is compiled in.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  frame in progress (state != IDLE).
- grant_idx_o  output  $clog2(NumReq)  index of the requester owning the current or last frame.

Behaviour:
- Reset values: tx_o=1, busy_o=0, req_ready_o=0, grant_idx_o=0, rr pointer=0, state=IDLE.
- States: IDLE, START, DATA, PARITY (present only with the optional feature), STOP.
- Ready generation (IDLE only): req_ready_o[k] is combinationally high when state==IDLE, tx_enable_i=1, and k is the first valid requester scanning k = ptr, ptr+1, ... mod NumReq. All ready bits are 0 in every other state.
- Handshake is valid&ready. In the same cycle:
  - the byte is latched;
  - bit_cycles_i is latched (0 becomes 1);
  - grant_idx_o is set to k;
  - ptr is set to (k+1) mod NumReq;
  - the next state is START.
- Requesters hold valid and data stable until ready. Dropping valid before ready is legal; that requester is simply not granted.
- Latency: tx_o goes 0 on the clock edge after the handshake cycle.
- Each bit lasts exactly the latched period P cycles. A down-counter loads P-1 on bit entry; the bit ends when the counter reaches 0.
- START: tx_o=0 for P cycles, then DATA.
- DATA: 8 bits, LSB first, with a 3-bit index. After bit 7: go to PARITY if the feature is compiled in, else STOP.
- STOP: tx_o=1 for P cycles, then IDLE.
- Minimum high time between frames: P+1 cycles (STOP plus one IDLE cycle for the handshake).
- Mid-frame changes:
  - tx_enable_i deasserted mid-frame: the current frame completes; no further grants.
  - bit_cycles_i changed mid-frame: no effect until the next handshake.
- A single requester holding valid continuously gets back-to-back frames. Other requesters with valid asserted are guaranteed a grant within NumReq frames.
- Async reset mid-frame: all outputs return to reset values immediately; the partial frame is abandoned.
- tx_o is driven from a register, so it is glitch-free.

Optional Feature:
- Macro: UART_TX_ARBITER_PARITY_EN.
- Defined:
  - PARITY state follows DATA and lasts P cycles.
  - Parity bit value is ^data XOR parity_odd_i.
  - Frame is 11 bits.
- Undefined:
  - No PARITY state; frame is 10 bits.
  - parity_odd_i is unused and may be left unconnected.

Test Plan:
- Reset then idle: hold rst_ni=0 then release with no valids -> tx_o=1, busy_o=0, req_ready_o=0000.
- Single frame timing: bit_cycles_i=4, req 2 sends 8'hA5 -> handshake cycle, then tx_o=0 for 4 cycles, data 1,0,1,0,0,1,0,1 each for 4 cycles, stop high for 4 cycles (40 cycles total without parity); grant_idx_o=2.
- Round-robin: all four valid continuously, bit_cycles_i=1 -> grant order 0,1,2,3,0; each next handshake occurs 1 cycle after the previous frame's STOP ends.
- Period edge: bit_cycles_i=0 -> each bit lasts 1 cycle. Change bit_cycles_i from 2 to 8 mid-frame -> current frame stays at 2 cycles/bit, next frame uses 8.
- Enable and reset mid-frame: deassert tx_enable_i during DATA -> frame finishes, no new ready while valids are held. Assert rst_ni=0 during DATA -> tx_o=1 and busy_o=0 immediately.
- With UART_TX_ARBITER_PARITY_EN, data 8'h07 -> parity bit 1 with parity_odd_i=0 and 0 with parity_odd_i=1; frame is 11*P cycles.
